lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
Shares one single-port unified memory between the LC3 Fetch stage (instruction reads) and the MemAccess stage (data reads/writes, including each phase of LDI/STI). It grants one requester at a time and sequences a fixed-latency access, then returns read data with a one-cycle completion pulse (complete_instr / complete_data equivalents). Data accesses have priority, with a streak limit that prevents fetch starvation. A branch-flush input discards an in-flight fetch.

Parameters:
MEM_LATENCY, 2, cycles the memory needs per access (legal 1..15); read data is valid on mem_dout in the last access cycle.
MAX_DATA_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced (legal 1..15).

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
if_req  in  1  fetch request; held high until if_done or flush.
if_addr  in  16  fetch address (PC).
if_flush  in  1  branch taken; cancels the in-flight or pending fetch.
if_data  out  16  fetched instruction; valid while if_done=1, held afterwards.
if_done  out  1  one-cycle fetch completion pulse.
d_req  in  1  data request; held high until d_done.
d_we  in  1  1 = write, 0 = read.
d_addr  in  16  data address.
d_din  in  16  write data.
d_dout  out  16  read data; valid while d_done=1, held afterwards; not updated by writes.
d_done  out  1  one-cycle data completion pulse.
mem_en  out  1  memory access active.
mem_rd  out  1  1 = read, 0 = write.
mem_addr  out  16  memory address.
mem_din  out  16  memory write data.
mem_dout  in  16  memory read data.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 except mem_rd=1. State is IDLE, counter 0, streak 0, flush flag 0.
- States: IDLE, F_ACC, D_ACC, DONE.
- IDLE arbitration, evaluated at the clock edge:
  - If d_req=1 and not (if_req=1, if_flush=0, streak==MAX_DATA_STREAK): grant data.
  - Else if if_req=1 and if_flush=0: grant fetch.
  - Else: stay in IDLE.
- On grant: latch addr, we and din; counter←MEM_LATENCY; go to F_ACC or D_ACC.
- Streak counter:
  - Data grant while if_req=1: streak+1, saturating.
  - Data grant while if_req=0: streak←0.
  - Fetch grant: streak←0.
- F_ACC / D_ACC:
  - Outputs: mem_en=1, mem_addr=latched address, mem_rd=~latched_we (1 for fetch), mem_din=latched din (0 for fetch).
  - Counter decrements each cycle.
  - When counter==1: capture mem_dout into if_data or d_dout (reads only), then go to DONE.
- DONE: lasts exactly one cycle; the matching done output is 1; mem_en=0. Always returns to IDLE; no grant is made from DONE.
- Timing: a request sampled at edge N gives done high during cycle N+MEM_LATENCY+1. Back-to-back accesses cost MEM_LATENCY+2 cycles each.
- Requester rule: deassert req or present the next request in the cycle after done. A req still high in IDLE is a new request.
- Flush:
  - if_flush=1 in any cycle of F_ACC sets the flush flag.
  - The memory cycle still completes, but in DONE if_done stays 0 and if_data is not updated.
  - The flag clears in DONE.
  - if_flush has no effect on D_ACC.
- Simultaneous d_req and if_req in IDLE: data wins unless the streak limit is reached.
- A request arriving during an access waits; there is no preemption.
- Reset during F_ACC, D_ACC or DONE: next state is IDLE, outputs return to reset values, no done pulse, streak cleared, flush flag cleared.
- Address and data ports are 16 bits throughout. There is no arithmetic on addresses; the counter is 4 bits.

Test Plan:
1. Reset with both reqs high: after reset deasserts, if_req=1, if_addr=16'h3000, mem_dout=16'h1234 → mem_en high for 2 cycles with mem_addr=16'h3000 and mem_rd=1; if_done pulses once with if_data=16'h1234, 3 cycles after the grant edge.
2. Data write: d_req=1, d_we=1, d_addr=16'h4000, d_din=16'hBEEF → mem_rd=0, mem_din=16'hBEEF for 2 cycles; d_done pulses once; d_dout unchanged.
3. Simultaneous requests: d_req and if_req asserted in the same IDLE cycle → D_ACC first (mem_addr=d_addr), then F_ACC after an idle turnaround; the done pulses are ordered d_done then if_done.
4. Starvation guard: d_req held continuously with if_req high and MAX_DATA_STREAK=4 → exactly 4 data accesses, then 1 fetch access, then data resumes.
5. Flush: if_flush pulses during the second cycle of F_ACC → no if_done pulse and if_data holds its old value; a following fetch request to 16'h3005 completes normally.
6. Reset mid-access: reset asserted during D_ACC → next cycle mem_en=0, busy=0, no d_done pulse; a new read request then completes with the full latency.

Source files
------------

// File: rtl/lc3_mem_arbiter_if.sv
// Requester and memory-side bus for the LC3 unified memory arbiter.
// The master side is the fetch/mem-access stages plus the memory model.
interface lc3_mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic [15:0] if_data;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_din;
    logic [15:0] d_dout;
    logic        d_done;
    logic        mem_en;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        busy;

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_din,
        output mem_dout,
        input  if_data, if_done, d_dout, d_done,
        input  mem_en, mem_rd, mem_addr, mem_din, busy
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_din,
        input  mem_dout,
        output if_data, if_done, d_dout, d_done,
        output mem_en, mem_rd, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Single-port memory arbiter between LC3 fetch and mem-access stages.
// Data has priority, bounded by a streak limit so fetch cannot starve.
module lc3_mem_arbiter #(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic              clock,
    input logic              reset,
    lc3_mem_arbiter_if.slave bus
);

    localparam logic [3:0] LAT  = 4'(MEM_LATENCY);
    localparam logic [3:0] MAXS = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        F_ACC,
        D_ACC,
        DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_streak;
    logic        r_flush;
    logic [15:0] r_if_data;
    logic        r_if_done;
    logic [15:0] r_d_dout;
    logic        r_d_done;
    logic        r_mem_en;
    logic        r_mem_rd;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_din;
    logic        r_busy;

    logic w_fetch_ok;
    logic w_force_f;
    logic w_grant_d;
    logic w_grant_f;
    logic w_flush_now;

    assign w_fetch_ok  = bus.if_req && !bus.if_flush;
    assign w_force_f   = w_fetch_ok && (r_streak == MAXS);
    assign w_grant_d   = bus.d_req && !w_force_f;
    assign w_grant_f   = !w_grant_d && w_fetch_ok;
    assign w_flush_now = r_flush || bus.if_flush;

    assign bus.if_data  = r_if_data;
    assign bus.if_done  = r_if_done;
    assign bus.d_dout   = r_d_dout;
    assign bus.d_done   = r_d_done;
    assign bus.mem_en   = r_mem_en;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.busy     = r_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_streak   <= 4'd0;
            r_flush    <= 1'b0;
            r_if_data  <= 16'd0;
            r_if_done  <= 1'b0;
            r_d_dout   <= 16'd0;
            r_d_done   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= 16'd0;
            r_mem_din  <= 16'd0;
            r_busy     <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= D_ACC;
                        r_cnt      <= LAT;
                        r_mem_en   <= 1'b1;
                        r_mem_rd   <= ~bus.d_we;
                        r_mem_addr <= bus.d_addr;
                        r_mem_din  <= bus.d_din;
                        r_busy     <= 1'b1;
                        // Streak only grows while a fetch is actually waiting
                        if (!bus.if_req)
                            r_streak <= 4'd0;
                        else if (r_streak != 4'hF)
                            r_streak <= r_streak + 4'd1;
                    end else if (w_grant_f) begin
                        r_state    <= F_ACC;
                        r_cnt      <= LAT;
                        r_mem_en   <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= bus.if_addr;
                        r_mem_din  <= 16'd0;
                        r_busy     <= 1'b1;
                        r_streak   <= 4'd0;
                    end
                end
                F_ACC, D_ACC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_state == F_ACC && bus.if_flush)
                        r_flush <= 1'b1;
                    if (r_cnt == 4'd1) begin
                        r_state    <= DONE;
                        r_mem_en   <= 1'b0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= 16'd0;
                        r_mem_din  <= 16'd0;
                        if (r_state == F_ACC) begin
                            if (!w_flush_now) begin
                                r_if_data <= bus.mem_dout;
                                r_if_done <= 1'b1;
                            end
                        end else begin
                            if (r_mem_rd)
                                r_d_dout <= bus.mem_dout;
                            r_d_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_flush <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: fetch, write, priority,
// streak guard, flush and mid-access reset.
module tb_lc3_mem_arbiter;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_bad;

    int          n_en;
    int          lat;
    logic [15:0] a_seen;
    logic        rd_seen;
    logic [15:0] din_seen;
    logic        fd;
    logic        dd;
    logic [15:0] seq [6];

    lc3_mem_arbiter_if bus ();

    lc3_mem_arbiter #(
        .MEM_LATENCY    (2),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Follows one access from its grant edge to the DONE cycle.
    task automatic acc();
        n_en = 0; lat = 0; fd = 1'b0; dd = 1'b0;
        a_seen = 16'd0; rd_seen = 1'b0; din_seen = 16'd0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.mem_en) begin
                if (n_en == 0) begin
                    a_seen   = bus.mem_addr;
                    rd_seen  = bus.mem_rd;
                    din_seen = bus.mem_din;
                end
                n_en++;
            end else if (n_en > 0) begin
                fd = bus.if_done;
                dd = bus.d_done;
                break;
            end
        end
    endtask

    task automatic release_reqs();
        @(posedge clock);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clock);
        chk("pulse_if", 16'(bus.if_done), 16'd0);
        chk("pulse_d", 16'(bus.d_done), 16'd0);
        chk("idle_busy", 16'(bus.busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.if_req = 1'b1;
        bus.if_addr = 16'h0;
        bus.if_flush = 1'b0;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 16'h0;
        bus.d_din = 16'h0;
        bus.mem_dout = 16'h0;

        // 1: reset with both requests high, then one fetch
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_en", 16'(bus.mem_en), 16'd0);
        chk("rst_rd", 16'(bus.mem_rd), 16'd1);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'({bus.if_done, bus.d_done}), 16'd0);
        chk("rst_addr", bus.mem_addr, 16'h0);
        chk("rst_ifdata", bus.if_data, 16'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.d_req = 1'b0;
        bus.if_addr = 16'h3000;
        bus.mem_dout = 16'h1234;
        acc();
        chk("f1_nen", 16'(n_en), 16'd2);
        chk("f1_addr", a_seen, 16'h3000);
        chk("f1_rd", 16'(rd_seen), 16'd1);
        chk("f1_lat", 16'(lat), 16'd3);
        chk("f1_done", 16'({fd, dd}), 16'b10);
        chk("f1_data", bus.if_data, 16'h1234);
        release_reqs();

        // 2: data write
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 16'h4000;
        bus.d_din = 16'hBEEF;
        bus.mem_dout = 16'h5555;
        acc();
        chk("w_nen", 16'(n_en), 16'd2);
        chk("w_addr", a_seen, 16'h4000);
        chk("w_rd", 16'(rd_seen), 16'd0);
        chk("w_din", din_seen, 16'hBEEF);
        chk("w_done", 16'({fd, dd}), 16'b01);
        chk("w_dout", bus.d_dout, 16'h0);
        release_reqs();

        // 3: simultaneous requests, data first
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 16'h4010;
        bus.if_req = 1'b1;
        bus.if_addr = 16'h3002;
        bus.mem_dout = 16'hA5A5;
        acc();
        chk("s_daddr", a_seen, 16'h4010);
        chk("s_ddone", 16'({fd, dd}), 16'b01);
        chk("s_dout", bus.d_dout, 16'hA5A5);
        @(posedge clock);
        #1;
        bus.d_req = 1'b0;
        bus.mem_dout = 16'h1111;
        @(negedge clock);
        chk("s_turn", 16'(bus.busy), 16'd0);
        acc();
        chk("s_faddr", a_seen, 16'h3002);
        chk("s_fdone", 16'({fd, dd}), 16'b10);
        chk("s_fdata", bus.if_data, 16'h1111);
        release_reqs();

        // 4: streak guard
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 16'h5000;
        bus.if_req = 1'b1;
        bus.if_addr = 16'h3100;
        bus.mem_dout = 16'h7777;
        for (int i = 0; i < 6; i++) begin
            acc();
            seq[i] = a_seen;
            @(posedge clock);
            #1;
            if (fd) bus.if_req = 1'b0;
        end
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        chk("st_0", seq[0], 16'h5000);
        chk("st_1", seq[1], 16'h5000);
        chk("st_2", seq[2], 16'h5000);
        chk("st_3", seq[3], 16'h5000);
        chk("st_4", seq[4], 16'h3100);
        chk("st_5", seq[5], 16'h5000);
        @(negedge clock);

        // 5: flush during second fetch cycle
        bus.if_req = 1'b1;
        bus.if_addr = 16'h3004;
        bus.mem_dout = 16'hDEAD;
        @(posedge clock);
        @(negedge clock);
        chk("fl_en", 16'(bus.mem_en), 16'd1);
        @(posedge clock);
        #1;
        bus.if_flush = 1'b1;
        @(posedge clock);
        #1;
        bus.if_flush = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clock);
        chk("fl_done", 16'(bus.if_done), 16'd0);
        chk("fl_busy", 16'(bus.busy), 16'd1);
        chk("fl_en2", 16'(bus.mem_en), 16'd0);
        chk("fl_hold", bus.if_data, 16'h7777);
        @(posedge clock);
        #1;
        bus.if_req = 1'b1;
        bus.if_addr = 16'h3005;
        bus.mem_dout = 16'hCAFE;
        acc();
        chk("fl2_addr", a_seen, 16'h3005);
        chk("fl2_done", 16'({fd, dd}), 16'b10);
        chk("fl2_data", bus.if_data, 16'hCAFE);
        release_reqs();

        // 6: reset mid data access
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 16'h6000;
        bus.mem_dout = 16'h4321;
        @(posedge clock);
        @(negedge clock);
        chk("mr_en", 16'(bus.mem_en), 16'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.d_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("mr_en2", 16'(bus.mem_en), 16'd0);
        chk("mr_busy", 16'(bus.busy), 16'd0);
        chk("mr_done", 16'(bus.d_done), 16'd0);
        chk("mr_rd", 16'(bus.mem_rd), 16'd1);
        chk("mr_dout", bus.d_dout, 16'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mr_done2", 16'(bus.d_done), 16'd0);
        bus.d_req = 1'b1;
        bus.d_addr = 16'h6002;
        bus.mem_dout = 16'h0BAD;
        acc();
        chk("mr2_nen", 16'(n_en), 16'd2);
        chk("mr2_lat", 16'(lat), 16'd3);
        chk("mr2_done", 16'({fd, dd}), 16'b01);
        chk("mr2_dout", bus.d_dout, 16'h0BAD);
        release_reqs();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
